// File: rtl/icache_refill_ctrl_pkg.sv
// Shared I-cache definitions: line geometry, tag memory entry and refill FSM states.
package icache_refill_ctrl_pkg;

  localparam int unsigned ICACHE_AW        = 32;
  localparam int unsigned ICACHE_BURST_LEN = 4;
  localparam int unsigned ICACHE_LINE_OFFS = $clog2(ICACHE_BURST_LEN) + 2;
  localparam int unsigned TAG_XLEN         = ICACHE_AW - ICACHE_LINE_OFFS;

  typedef struct packed {
    logic                valid;
    logic [TAG_XLEN-1:0] tag;
  } type_icache_tag_mem_s;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REFILL_REQ,
    ST_REFILL_DATA,
    ST_TAG_WRITE,
    ST_DONE
  } type_icache_refill_state_e;

endpackage

// File: rtl/icache_refill_ctrl.sv
// I-cache lookup/refill controller: tag lookup against the tag FIFO, line burst
// into the data RAM victim way, tag install and fetch acknowledge.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int unsigned DP        = 4,
  parameter int unsigned BURST_LEN = ICACHE_BURST_LEN,
  parameter int unsigned AW        = ICACHE_AW
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       flush,
  input  logic                                       cpu_req,
  input  logic [AW-1:0]                              cpu_addr,
  output logic                                       cpu_ack,
  output logic                                       cpu_err,
  output logic [$clog2(DP)-1:0]                      cpu_hindex,
  output logic [TAG_XLEN-1:0]                        tag_cmp_data,
  input  logic [DP-1:0]                              tag_hit,
  input  logic [$clog2(DP)-1:0]                      tag_wptr,
  output logic                                       tag_wr,
  output type_icache_tag_mem_s                       tag_wdata,
  output logic                                       mem_req,
  output logic [AW-1:0]                              mem_addr,
  input  logic                                       mem_gnt,
  input  logic                                       mem_rvalid,
  input  logic [31:0]                                mem_rdata,
  input  logic                                       mem_err,
  output logic                                       dram_wr,
  output logic [$clog2(DP)+$clog2(BURST_LEN)-1:0]    dram_waddr,
  output logic [31:0]                                dram_wdata
);

  localparam int unsigned IW   = $clog2(DP);
  localparam int unsigned BW   = $clog2(BURST_LEN);
  localparam int unsigned OFFS = BW + 2;

  type_icache_refill_state_e state_q, state_d;

  logic [AW-1:0]         addr_q, addr_d;
  logic [IW-1:0]         victim_q, victim_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic                  err_flag_q, err_d;
  logic                  flush_pend_q, pend_d;
  logic [IW-1:0]         hit_idx;
  logic [TAG_XLEN-1:0]   cur_tag;
  logic [AW-1:0]         line_addr;

  logic                  cpu_ack_d, cpu_err_d, tag_wr_d, mem_req_d, dram_wr_d;
  logic [IW-1:0]         cpu_hindex_d;
  type_icache_tag_mem_s  tag_wdata_d;
  logic [AW-1:0]         mem_addr_d;
  logic [IW+BW-1:0]      dram_waddr_d;
  logic [31:0]           dram_wdata_d;

  assign cur_tag      = TAG_XLEN'(addr_q >> OFFS);
  assign line_addr    = {addr_q[AW-1:OFFS], {OFFS{1'b0}}};
  assign tag_cmp_data = cur_tag;

  // Highest set hit bit wins, matching the tag FIFO's own priority
  always_comb begin
    hit_idx = '0;
    for (int unsigned i = 0; i < DP; i++) begin
      if (tag_hit[i]) hit_idx = IW'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    victim_d     = victim_q;
    beat_d       = beat_q;
    err_d        = err_flag_q;
    pend_d       = flush_pend_q;
    cpu_ack_d    = 1'b0;
    cpu_err_d    = 1'b0;
    cpu_hindex_d = '0;
    tag_wr_d     = 1'b0;
    tag_wdata_d  = '0;
    mem_req_d    = 1'b0;
    mem_addr_d   = mem_addr;
    dram_wr_d    = 1'b0;
    dram_waddr_d = '0;
    dram_wdata_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          state_d = ST_LOOKUP;
        end
      end

      // A flush this cycle invalidates the FIFO, so any hit is stale
      ST_LOOKUP: begin
        if ((|tag_hit) && !flush) begin
          cpu_ack_d    = 1'b1;
          cpu_hindex_d = hit_idx;
          state_d      = ST_DONE;
        end else begin
          victim_d   = tag_wptr;
          beat_d     = '0;
          pend_d     = 1'b0;
          mem_req_d  = 1'b1;
          mem_addr_d = line_addr;
          state_d    = ST_REFILL_REQ;
        end
      end

      ST_REFILL_REQ: begin
        pend_d = flush_pend_q | flush;
        if (mem_gnt) begin
          state_d = ST_REFILL_DATA;
        end else begin
          mem_req_d = 1'b1;
        end
      end

      // Memory cannot abort a burst: every beat is consumed even after an error
      ST_REFILL_DATA: begin
        pend_d = flush_pend_q | flush;
        if (mem_rvalid) begin
          if (mem_err) begin
            err_d = 1'b1;
          end else if (!err_flag_q) begin
            dram_wr_d    = 1'b1;
            dram_waddr_d = {victim_q, beat_q};
            dram_wdata_d = mem_rdata;
          end
          beat_d = beat_q + BW'(1);
          if (beat_q == BW'(BURST_LEN - 1)) state_d = ST_TAG_WRITE;
        end
      end

      // After a flush the line is refetched, so stale burst errors are dropped
      ST_TAG_WRITE: begin
        if (flush_pend_q || flush) begin
          pend_d  = 1'b0;
          err_d   = 1'b0;
          state_d = ST_LOOKUP;
        end else begin
          if (!err_flag_q) begin
            tag_wr_d    = 1'b1;
            tag_wdata_d = '{valid: 1'b1, tag: cur_tag};
          end
          cpu_ack_d    = 1'b1;
          cpu_err_d    = err_flag_q;
          cpu_hindex_d = victim_q;
          state_d      = ST_DONE;
        end
      end

      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      victim_q     <= '0;
      beat_q       <= '0;
      err_flag_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      cpu_ack      <= 1'b0;
      cpu_err      <= 1'b0;
      cpu_hindex   <= '0;
      tag_wr       <= 1'b0;
      tag_wdata    <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      dram_wr      <= 1'b0;
      dram_waddr   <= '0;
      dram_wdata   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      victim_q     <= victim_d;
      beat_q       <= beat_d;
      err_flag_q   <= err_d;
      flush_pend_q <= pend_d;
      cpu_ack      <= cpu_ack_d;
      cpu_err      <= cpu_err_d;
      cpu_hindex   <= cpu_hindex_d;
      tag_wr       <= tag_wr_d;
      tag_wdata    <= tag_wdata_d;
      mem_req      <= mem_req_d;
      mem_addr     <= mem_addr_d;
      dram_wr      <= dram_wr_d;
      dram_waddr   <= dram_waddr_d;
      dram_wdata   <= dram_wdata_d;
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized bench for icache_refill_ctrl with a tag FIFO stand-in, a burst memory
// responder and a transaction-level cache model predicting each fetch outcome.
module tb_icache_refill_ctrl;
  import icache_refill_ctrl_pkg::*;

  localparam int unsigned DP   = 4;
  localparam int unsigned BL   = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned IW   = 2;
  localparam int unsigned BW   = 2;
  localparam int unsigned OFFS = 4;

  logic                 clk, reset, flush, cpu_req;
  logic [AW-1:0]        cpu_addr;
  logic                 cpu_ack, cpu_err;
  logic [IW-1:0]        cpu_hindex;
  logic [TAG_XLEN-1:0]  tag_cmp_data;
  logic [DP-1:0]        tag_hit;
  logic [IW-1:0]        tag_wptr;
  logic                 tag_wr;
  type_icache_tag_mem_s tag_wdata;
  logic                 mem_req, mem_gnt, mem_rvalid, mem_err;
  logic [AW-1:0]        mem_addr;
  logic [31:0]          mem_rdata;
  logic                 dram_wr;
  logic [IW+BW-1:0]     dram_waddr;
  logic [31:0]          dram_wdata;

  icache_refill_ctrl #(.DP(DP), .BURST_LEN(BL), .AW(AW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .cpu_hindex(cpu_hindex), .tag_cmp_data(tag_cmp_data), .tag_hit(tag_hit),
    .tag_wptr(tag_wptr), .tag_wr(tag_wr), .tag_wdata(tag_wdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err),
    .dram_wr(dram_wr), .dram_waddr(dram_waddr), .dram_wdata(dram_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] line, input int b);
    return line ^ 32'hA5A5_0000 ^ (32'(b) * 32'h0101_0101);
  endfunction

  // Tag FIFO stand-in: round-robin victim pointer, flush invalidates all ways
  logic [DP-1:0]       env_valid;
  logic [TAG_XLEN-1:0] env_tag [DP];
  logic [IW-1:0]       env_wptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      env_valid <= '0;
      env_wptr  <= '0;
      for (int i = 0; i < DP; i++) env_tag[i] <= '0;
    end else if (flush) begin
      env_valid <= '0;
      env_wptr  <= '0;
    end else if (tag_wr) begin
      env_valid[env_wptr] <= tag_wdata.valid;
      env_tag[env_wptr]   <= tag_wdata.tag;
      env_wptr            <= env_wptr + IW'(1);
    end
  end

  always_comb begin
    tag_hit = '0;
    for (int i = 0; i < DP; i++) tag_hit[i] = env_valid[i] && (env_tag[i] == tag_cmp_data);
  end
  assign tag_wptr = env_wptr;

  // Observed traffic, appended only by the monitor / memory processes
  logic [63:0] wr_q[$];
  logic [63:0] tw_q[$];
  logic [31:0] mem_a[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (dram_wr) wr_q.push_back({32'(dram_waddr), dram_wdata});
      if (tag_wr)  tw_q.push_back(64'(tag_wdata));
    end
  end

  // Fault injection knobs, applied to burst number inj_burst only
  int burst_cnt = 0;
  int inj_burst = -1;
  int inj_err   = -1;
  int inj_flush = -1;

  initial begin
    int gap, cur;
    bit aborted;
    logic [31:0] line;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0; flush = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req && !reset) begin
        aborted = 1'b0;
        gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++) begin
          @(negedge clk);
          if (reset) aborted = 1'b1;
        end
        if (!aborted && mem_req && !reset) begin
          mem_gnt = 1'b1;
          line    = mem_addr;
          mem_a.push_back(mem_addr);
          cur = burst_cnt;
          burst_cnt++;
          @(negedge clk);
          mem_gnt = 1'b0;
          for (int b = 0; b < BL; b++) begin
            if (reset) break;
            if ($urandom_range(0, 3) == 0) begin
              @(negedge clk);
              if (reset) break;
            end
            mem_rvalid = 1'b1;
            mem_rdata  = beat_data(line, b);
            mem_err    = (cur == inj_burst) && (b == inj_err);
            flush      = (cur == inj_burst) && (b == inj_flush);
            @(negedge clk);
            mem_rvalid = 1'b0; mem_err = 1'b0; flush = 1'b0;
          end
        end
      end
    end
  end

  // Cache contents model: what the tag FIFO should hold after each fetch
  bit                  ref_valid [DP];
  logic [TAG_XLEN-1:0] ref_tag [DP];
  int                  ref_wptr;

  task automatic ref_clear();
    for (int w = 0; w < DP; w++) ref_valid[w] = 1'b0;
    ref_wptr = 0;
  endtask

  task automatic do_txn(input logic [31:0] addr, input int err_beat, input int flush_beat,
                        output bit got_err);
    logic [TAG_XLEN-1:0] tag;
    logic [31:0] line;
    logic [63:0] exp_w[$];
    logic [63:0] exp_tw[$];
    logic [31:0] exp_a[$];
    int hit_way, v, n, w0, t0, a0, exp_hidx;
    bit got, exp_err;
    logic obs_err;
    logic [IW-1:0] obs_hidx;

    tag  = TAG_XLEN'(addr >> OFFS);
    line = addr & ~32'(BL * 4 - 1);
    hit_way = -1;
    for (int w = 0; w < DP; w++) if (ref_valid[w] && ref_tag[w] == tag) hit_way = w;
    exp_err = 1'b0; exp_hidx = hit_way; got_err = 1'b0;

    if (hit_way < 0) begin
      v = ref_wptr;
      exp_a.push_back(line);
      if (flush_beat >= 0) begin
        for (int b = 0; b < BL; b++) exp_w.push_back({32'(v * BL + b), beat_data(line, b)});
        ref_clear();
        v = 0;
        exp_a.push_back(line);
      end
      for (int b = 0; b < BL; b++)
        if (err_beat < 0 || b < err_beat) exp_w.push_back({32'(v * BL + b), beat_data(line, b)});
      if (err_beat < 0) begin
        exp_tw.push_back(64'({1'b1, tag}));
        ref_valid[v] = 1'b1;
        ref_tag[v]   = tag;
        ref_wptr     = (v + 1) % DP;
        exp_hidx     = v;
      end else begin
        exp_err = 1'b1;
        got_err = 1'b1;
      end
    end

    inj_burst = burst_cnt;
    inj_err   = (hit_way < 0) ? err_beat : -1;
    inj_flush = (hit_way < 0) ? flush_beat : -1;
    w0 = wr_q.size(); t0 = tw_q.size(); a0 = mem_a.size();

    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = addr;
    got = 1'b0; n = 0; obs_err = 1'b0; obs_hidx = '0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (cpu_ack) begin
        got = 1'b1; obs_err = cpu_err; obs_hidx = cpu_hindex;
      end
    end
    cpu_req = 1'b0;
    @(negedge clk);

    check("ack_seen", 64'(got), 64'(1));
    check("ack_pulse", 64'(cpu_ack), 64'(0));
    if (hit_way >= 0) check("hit_latency", 64'(n), 64'(2));
    check("cpu_err", 64'(obs_err), 64'(exp_err));
    if (!exp_err) check("cpu_hindex", 64'(obs_hidx), 64'(exp_hidx));
    check("mem_req_cnt", 64'(mem_a.size() - a0), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && a0 + i < mem_a.size(); i++)
      check("mem_addr", 64'(mem_a[a0 + i]), 64'(exp_a[i]));
    check("dram_wr_cnt", 64'(wr_q.size() - w0), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && w0 + i < wr_q.size(); i++)
      check("dram_wr", wr_q[w0 + i], exp_w[i]);
    check("tag_wr_cnt", 64'(tw_q.size() - t0), 64'(exp_tw.size()));
    for (int i = 0; i < exp_tw.size() && t0 + i < tw_q.size(); i++)
      check("tag_wdata", tw_q[t0 + i], exp_tw[i]);
  endtask

  initial begin
    logic [31:0] pool [6];
    logic [31:0] addr, prev_addr;
    bit prev_err, e, seen;
    int sel, eb, fb;

    pool[0] = 32'h123; pool[1] = 32'h456; pool[2] = 32'h777;
    pool[3] = 32'h9AB; pool[4] = 32'hCDE; pool[5] = 32'h111;
    reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0;
    ref_clear();
    repeat (3) @(negedge clk);

    check("rst_cpu_ack", 64'(cpu_ack), 64'(0));
    check("rst_cpu_err", 64'(cpu_err), 64'(0));
    check("rst_cpu_hindex", 64'(cpu_hindex), 64'(0));
    check("rst_tag_wr", 64'(tag_wr), 64'(0));
    check("rst_tag_wdata", 64'(tag_wdata), 64'(0));
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_dram_wr", 64'(dram_wr), 64'(0));
    check("rst_tag_cmp", 64'(tag_cmp_data), 64'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    do_txn(32'h0000_4568, -1, -1, e);   // miss into way 0
    do_txn(32'h0000_1000, -1, -1, e);
    do_txn(32'h0000_1230, -1, -1, e);   // way 2 holds 0x123
    do_txn(32'h0000_1234, -1, -1, e);   // hit way 2
    do_txn(32'h0000_7770, -1, -1, e);   // victim way 3
    do_txn(32'h0000_2000,  1, -1, e);   // bus error on beat 1
    do_txn(32'h0000_2000, -1, -1, e);   // same line refills again
    do_txn(32'h0000_3000, -1,  2, e);   // flush mid-burst, refetch into way 0
    do_txn(32'h0000_3004, -1, -1, e);   // hit after flush refill

    prev_err = 1'b0; prev_addr = '0;
    for (int t = 0; t < 150; t++) begin
      if (prev_err) addr = prev_addr;
      else addr = (pool[$urandom_range(0, 5)] << OFFS) | 32'($urandom_range(0, 15));
      sel = $urandom_range(0, 9);
      eb = -1; fb = -1;
      if (sel == 0) eb = $urandom_range(0, BL - 1);
      else if (sel == 1) fb = $urandom_range(0, BL - 1);
      do_txn(addr, eb, fb, e);
      prev_err = e; prev_addr = addr;
    end

    // Reset in the middle of a refill burst
    inj_burst = -1; inj_err = -1; inj_flush = -1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'hDEAD_BEE0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (dram_wr) seen = 1'b1;
    end
    check("rst_mid_reached", 64'(seen), 64'(1));
    reset = 1'b1;
    #1;
    check("rst_mid_mem_req", 64'(mem_req), 64'(0));
    check("rst_mid_dram_wr", 64'(dram_wr), 64'(0));
    check("rst_mid_tag_wr", 64'(tag_wr), 64'(0));
    check("rst_mid_cpu_ack", 64'(cpu_ack), 64'(0));
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ref_clear();
    repeat (2) @(negedge clk);
    do_txn(32'h0000_4568, -1, -1, e);
    do_txn(32'h0000_4560, -1, -1, e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Lookup and refill controller that sits directly upstream of icache_tag_fifo.
- Takes a CPU fetch request and drives tag_cmp_data, then evaluates the returned tag_hit vector.
- On a miss it bursts the line from memory into the data RAM way given by tag_wptr, then issues tag_wr with a valid tag.
- Returns the hit way index and ack (or error) to the fetch unit.

Parameters:
- DP, 4: tag FIFO depth, equal to the number of ways. Power of 2, range 4..256.
- BURST_LEN, 4: 32-bit words per cache line. Power of 2, range 2..16.
- AW, 32: CPU/memory byte-address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  cache flush; also wired to the tag FIFO flush in parallel
- cpu_req  in  1  fetch request; held until cpu_ack
- cpu_addr  in  AW  fetch byte address
- cpu_ack  out  1  one-cycle pulse: request complete
- cpu_err  out  1  valid with cpu_ack; refill bus error
- cpu_hindex  out  $clog2(DP)  way holding the line; valid with cpu_ack
- tag_cmp_data  out  TAG_XLEN  tag under lookup
- tag_hit  in  DP  tag FIFO hit vector (combinational from tag_cmp_data)
- tag_wptr  in  $clog2(DP)  tag FIFO next victim location
- tag_wr  out  1  tag write strobe
- tag_wdata  out  type_icache_tag_mem_s  {valid, tag}
- mem_req  out  1  burst read request
- mem_addr  out  AW  line-aligned burst address
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read beat valid
- mem_rdata  in  32  read beat data
- mem_err  in  1  beat error; qualified by mem_rvalid
- dram_wr  out  1  data RAM write strobe
- dram_waddr  out  $clog2(DP)+$clog2(BURST_LEN)  address {way, beat}
- dram_wdata  out  32  data RAM write data

Behaviour:
- Address split: OFFS = $clog2(BURST_LEN)+2. Tag = cpu_addr[OFFS +: TAG_XLEN]. mem_addr = {cpu_addr[AW-1:OFFS], OFFS'b0}.
- Reset values: state IDLE; all outputs 0; tag_wdata 0; internal address, victim and beat registers 0.
- FSM states: IDLE, LOOKUP, REFILL_REQ, REFILL_DATA, TAG_WRITE, DONE.
- IDLE: on cpu_req, register cpu_addr and go to LOOKUP. tag_cmp_data is driven from this registered address in every state.
- LOOKUP (1 cycle):
  - If |tag_hit: hindex = highest set bit index (matches the tag FIFO priority); go to DONE.
  - Else: latch victim = tag_wptr; go to REFILL_REQ.
- REFILL_REQ: mem_req=1 with mem_addr held. The cycle mem_gnt=1 goes to REFILL_DATA; mem_req deasserts in the following cycle.
- REFILL_DATA: for each mem_rvalid:
  - dram_wr=1, dram_waddr={victim, beat}, dram_wdata=mem_rdata; beat++.
  - On beat BURST_LEN-1, go to TAG_WRITE. Beat counter wraps to 0.
  - mem_err on any beat sets err_flag. The remaining beats are still consumed, but dram_wr is suppressed once err_flag is set.
- TAG_WRITE (1 cycle):
  - If err_flag=0: tag_wr=1, tag_wdata={1'b1, tag}, hindex=victim.
  - If err_flag=1: no tag_wr.
  - Go to DONE.
- DONE: cpu_ack=1 for exactly one cycle with cpu_hindex and cpu_err=err_flag; clear err_flag; go to IDLE. A request is accepted again in the next cycle.
- Latency:
  - Hit: req sampled at cycle 0 → ack at cycle 2.
  - Miss: 3 cycles + grant wait + BURST_LEN beat cycles.
- Flush, in each state:
  - IDLE / DONE: no effect on this block.
  - LOOKUP: forces a miss (the tag FIFO is being invalidated).
  - REFILL_REQ / REFILL_DATA: set flush_pend. The burst is drained completely (memory cannot abort), then TAG_WRITE suppresses tag_wr and the FSM returns to LOOKUP instead of DONE. The request is not dropped and is refilled into the post-flush tag_wptr.
  - TAG_WRITE: tag_wr is suppressed; go to LOOKUP.
- Simultaneous cpu_req and flush in IDLE: the request is accepted.
- Reset mid-refill: immediate return to IDLE; mem_req drops. The memory fabric must tolerate an abandoned burst.
- tag_uwr is not driven by this block; it is tied 0 at the parent.

Decomposition:
- Add to cache_defs.svh:
  - ICACHE_LINE_OFFS.
  - An enum type_icache_refill_state_e.
  - Reuse of type_icache_tag_mem_s and TAG_XLEN.
- No sub-module. The FSM plus beat counter is a single module, and icache_tag_fifo is instantiated beside it in the icache top.

Test Plan:
1. Hit. Tag FIFO holds tag 0x123 valid in way 2; cpu_addr=0x0000_1230 → cpu_ack at cycle 2, cpu_hindex=2, cpu_err=0, no mem_req.
2. Miss refill. Empty FIFO, tag_wptr=0; cpu_addr=0x0000_4568 → mem_addr=0x0000_4560, then 4 dram_wr at addr 0..3 with data 0xA0..0xA3, then tag_wr with {1,0x456}, then cpu_ack with hindex=0.
3. Victim wrap. FIFO full, tag_wptr=3; miss on 0x0000_7770 → dram_waddr 12..15, tag_wr with tag 0x777, hindex=3.
4. Bus error. mem_err on beat 1 → only beat 0 written, no tag_wr, cpu_ack with cpu_err=1. A following request to the same address misses and refills again.
5. Flush mid-burst. Flush asserted on beat 2 → all 4 beats consumed, no tag_wr, then re-LOOKUP, a second mem_req to the same line, and completion with hindex=0.
6. Reset mid-burst. Reset high during REFILL_DATA → mem_req, dram_wr, tag_wr and cpu_ack are all 0 immediately. After release, a new request proceeds normally.
